// File: rtl/sva_thread_sched_if.sv
// sva_thread_sched_if: request/response handshake between the thread sequencer and the shared next-state evaluator
interface sva_thread_sched_if #(
  parameter int STATE_W = 8
);
  logic               ev_req;
  logic [STATE_W-1:0] ev_state;
  logic               ev_ack;
  logic [STATE_W-1:0] ev_next;
  logic               ev_active;
  logic               ev_succ;
  logic               ev_fail;
  modport master (output ev_req, ev_state, input ev_ack, ev_next, ev_active, ev_succ, ev_fail);
  modport slave  (input ev_req, ev_state, output ev_ack, ev_next, ev_active, ev_succ, ev_fail);
endinterface

// File: rtl/sva_thread_sched.sv
// sva_thread_sched: walks SLOTS assertion threads through one shared evaluator per epoch, then spawns a new attempt; SVA_SCHED_STAMP_EN adds per-thread start stamps
module sva_thread_sched #(
  parameter int SLOTS   = 4,
  parameter int STATE_W = 8,
  parameter int TIMER_W = 16,
  parameter int CNT_W   = 16,
  localparam int AW = $clog2(SLOTS + 1),
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1
) (
  input  logic               gclk,
  input  logic               grst,
  input  logic               sample_stb,
  input  logic [TIMER_W-1:0] timer,
  sva_thread_sched_if.master ev,
  output logic               busy,
  output logic               succ_pulse,
  output logic               fail_pulse,
  output logic [TIMER_W-1:0] evt_start,
  output logic               overrun,
  output logic               drop,
  output logic [AW-1:0]      active_cnt,
  output logic [CNT_W-1:0]   succ_cnt,
  output logic [CNT_W-1:0]   fail_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, SPAWN} fsm_t;
  fsm_t fsm_q, fsm_d;
  logic [SLOTS-1:0] valid_q, valid_d, mask_q, mask_d;
  logic [SLOTS-1:0][STATE_W-1:0] st_q, st_d;
  logic succ_q, succ_d, fail_q, fail_d, ovr_q, ovr_d, drop_q, drop_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;
  logic [SW-1:0] sel, free;
  logic free_any, keep, hit, spawn_wr;
  assign busy        = fsm_q != IDLE;
  assign ev.ev_req   = busy;
  assign ev.ev_state = fsm_q == SCAN ? st_q[sel] : '0;
  assign keep        = ev.ev_active && !ev.ev_succ && !ev.ev_fail;
  assign hit         = busy && ev.ev_ack;
  assign spawn_wr    = fsm_q == SPAWN && ev.ev_ack && keep && free_any;
  assign succ_pulse  = succ_q;
  assign fail_pulse  = fail_q;
  assign overrun     = ovr_q;
  assign drop        = drop_q;
  assign succ_cnt    = scnt_q;
  assign fail_cnt    = fcnt_q;
  // lowest pending slot of this epoch's snapshot, lowest free slot, and occupancy
  always_comb begin
    sel = '0;
    free = '0;
    free_any = 1'b0;
    active_cnt = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (mask_q[i]) sel = SW'(i);
      if (!valid_q[i]) begin
        free = SW'(i);
        free_any = 1'b1;
      end
      active_cnt = active_cnt + AW'(valid_q[i]);
    end
  end
  // epoch sequencing and slot write-back; SCAN is entered only with a pending slot so an epoch costs k+1 acks
  always_comb begin
    fsm_d = fsm_q;
    mask_d = mask_q;
    valid_d = valid_q;
    st_d = st_q;
    if (fsm_q == IDLE && sample_stb) begin
      mask_d = valid_q;
      fsm_d = |valid_q ? SCAN : SPAWN;
    end
    if (fsm_q == SCAN && ev.ev_ack) begin
      mask_d[sel] = 1'b0;
      valid_d[sel] = keep;
      st_d[sel] = keep ? ev.ev_next : st_q[sel];
      fsm_d = (mask_q & ~(SLOTS'(1) << sel)) == '0 ? SPAWN : SCAN;
    end
    if (spawn_wr) begin
      valid_d[free] = 1'b1;
      st_d[free] = ev.ev_next;
    end
    if (fsm_q == SPAWN && ev.ev_ack) fsm_d = IDLE;
  end
  // event pulses (failure wins over success) and saturating counters
  always_comb begin
    fail_d = hit && ev.ev_fail;
    succ_d = hit && ev.ev_succ && !ev.ev_fail;
    ovr_d  = busy && sample_stb;
    drop_d = fsm_q == SPAWN && ev.ev_ack && keep && !free_any;
    scnt_d = succ_d && ~&scnt_q ? scnt_q + 1'b1 : scnt_q;
    fcnt_d = fail_d && ~&fcnt_q ? fcnt_q + 1'b1 : fcnt_q;
  end
  // state register; reset aborts any epoch without reporting
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      fsm_q <= IDLE;
      valid_q <= '0;
      mask_q <= '0;
      st_q <= '0;
      succ_q <= 1'b0;
      fail_q <= 1'b0;
      ovr_q <= 1'b0;
      drop_q <= 1'b0;
      scnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      valid_q <= valid_d;
      mask_q <= mask_d;
      st_q <= st_d;
      succ_q <= succ_d;
      fail_q <= fail_d;
      ovr_q <= ovr_d;
      drop_q <= drop_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
    end
  end
`ifdef SVA_SCHED_STAMP_EN
  logic [TIMER_W-1:0] ts_q, ts_d, evt_q, evt_d;
  logic [SLOTS-1:0][TIMER_W-1:0] start_q, start_d;
  // capture the epoch stamp at the strobe, store it with a spawned thread, report it with events
  always_comb begin
    ts_d = fsm_q == IDLE && sample_stb ? timer : ts_q;
    start_d = start_q;
    if (spawn_wr) start_d[free] = ts_q;
    evt_d = hit && (ev.ev_fail || ev.ev_succ) ? (fsm_q == SCAN ? start_q[sel] : ts_q) : '0;
  end
  // stamp registers
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      ts_q <= '0;
      start_q <= '0;
      evt_q <= '0;
    end else begin
      ts_q <= ts_d;
      start_q <= start_d;
      evt_q <= evt_d;
    end
  end
  assign evt_start = evt_q;
`else
  logic unused_timer;
  assign unused_timer = ^timer;
  assign evt_start = '0;
`endif
endmodule
